rs232tx_fifo: RTL and testbench
===============================

// Module: rs232tx_fifo
//
// PURPOSE
//   Transmit-side byte FIFO sitting directly upstream of the rs232tx serializer.
//   Buffers bytes written by the CPU/IO bus and hands them one at a time to
//   rs232tx over its d/we/busy interface, so software never spins per byte.
//   Provides fill level, full/empty status and a sticky overflow flag.
//
// PARAMETERS
//   DEPTH_LOG2  4   FIFO holds 2**DEPTH_LOG2 bytes (default 16); legal range 1..8
//
// PORTS
//   clock       in   1             system clock, all state on posedge
//   reset_n     in   1             asynchronous, active-low reset
//   wr_en       in   1             write strobe; wr_data pushed if not full
//   wr_data     in   8             byte to enqueue
//   flush       in   1             synchronous: discard all queued bytes
//   clr_ovf     in   1             synchronous: clear overflow flag
//   full        out  1             FIFO holds 2**DEPTH_LOG2 bytes
//   empty       out  1             FIFO holds 0 bytes
//   level       out  DEPTH_LOG2+1  number of queued bytes, 0..2**DEPTH_LOG2
//   overflow    out  1             sticky: a write was dropped while full
//   tx_d        out  8             byte to serializer (registered)
//   tx_we       out  1             one-cycle load strobe to serializer (registered)
//   tx_busy     in   1             serializer busy
//
// BEHAVIOUR
//   - Reset (async on reset_n low): level=0, empty=1, full=0, overflow=0,
//     tx_we=0, tx_d=8'h00, rd/wr pointers=0, FSM=IDLE. Storage RAM not reset.
//   - Storage: 2**DEPTH_LOG2 x 8 array; pointers DEPTH_LOG2 bits, wrap mod depth.
//     level is a separate counter (DEPTH_LOG2+1 bits); full/empty decoded from it.
//   - Push: wr_en & ~full -> mem[wr_ptr]<=wr_data, wr_ptr++. wr_en & full ->
//     byte dropped, overflow<=1. Status outputs update the cycle after the edge.
//   - Pop occurs only in FSM IDLE->ISSUE transition (below).
//   - Simultaneous push and pop: level unchanged; legal when full (push is
//     judged against pre-edge full, so it is dropped + overflow) and when
//     empty (no pop possible, push succeeds).
//   - FSM (drain side):
//       IDLE : if ~empty & ~tx_busy -> tx_d<=mem[rd_ptr], rd_ptr++, level--,
//              tx_we<=1, go ISSUE.
//       ISSUE: tx_we is high this cycle; serializer latches at end of it.
//              tx_we<=0, go HOLD.
//       HOLD : one guard cycle so tx_busy (which rises one cycle after the
//              load) is valid before IDLE samples it again. -> IDLE.
//     tx_we is therefore high for exactly one cycle per byte; never two in a row.
//   - Latency: byte written into empty FIFO with tx_busy=0 -> tx_we high two
//     cycles after the wr_en edge. Back-to-back bytes start as soon as tx_busy
//     falls (IDLE re-check every cycle); min spacing between tx_we pulses = 3.
//   - flush: rd_ptr<=wr_ptr<=0, level<=0 same edge; any concurrent wr_en is
//     ignored; flush has priority over pop (IDLE does not issue that cycle).
//     A byte already in ISSUE/HOLD or in the serializer completes normally.
//   - clr_ovf clears overflow; if a dropped write happens the same cycle,
//     set wins (overflow stays 1).
//   - Reset mid-transmission: FIFO emptied, tx_we forced 0; serializer has
//     its own state and is not this block's concern.
//
// TESTING
//   1 Reset: hold reset_n=0 -> empty=1, full=0, level=0, overflow=0, tx_we=0.
//   2 Single byte: tx_busy=0, write 8'hA5 -> tx_we=1 exactly 2 cycles later
//     with tx_d=8'hA5, one cycle wide; level returns to 0; empty=1.
//   3 Burst with busy model: write 8'h01..8'h05 back-to-back, tx_busy
//     driven by a rs232tx instance (period=4) -> 5 tx_we pulses in order
//     01..05, never while tx_busy=1, none adjacent.
//   4 Fill/overflow: tx_busy=1 stuck, write 17 bytes (DEPTH_LOG2=4) -> full=1
//     after 16, 17th dropped, overflow=1, level=16; clr_ovf -> overflow=0;
//     release busy -> first 16 bytes emerge in order, wrap verified.
//   5 Simultaneous: level=15, pop and push same cycle -> level stays 15;
//     at full with push+pop -> push dropped, overflow=1, level=15.
//   6 Flush/reset mid-burst: 6 queued, flush during HOLD -> in-flight byte
//     still completes, no further tx_we, level=0; repeat with reset_n pulse
//     asserted asynchronously mid-cycle -> all outputs at reset values at once.

Source files
------------

// File: rtl/rs232tx_fifo_if.sv
// ---------------------------------------------------------------------------
// rs232tx_fifo_if
//   Groups the CPU-side write/status signals and the serializer-side
//   d/we/busy handshake of the rs232tx transmit FIFO.
//
//   master : bus side plus serializer busy (drives wr_en, wr_data, flush,
//            clr_ovf, tx_busy; observes status and tx_d/tx_we)
//   slave  : the FIFO itself
//
//   Signals
//     wr_en, wr_data[7:0]   byte write strobe and data
//     flush, clr_ovf        synchronous discard / overflow clear
//     full, empty           decoded fill status
//     level                 queued byte count, 0..2**DEPTH_LOG2
//     overflow              sticky dropped-write flag
//     tx_d[7:0], tx_we      registered byte and load strobe to serializer
//     tx_busy               serializer busy
// ---------------------------------------------------------------------------
interface rs232tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  flush;
  logic                  clr_ovf;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic [7:0]            tx_d;
  logic                  tx_we;
  logic                  tx_busy;

  modport master (
    output wr_en, wr_data, flush, clr_ovf, tx_busy,
    input  full, empty, level, overflow, tx_d, tx_we
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_ovf, tx_busy,
    output full, empty, level, overflow, tx_d, tx_we
  );
endinterface

// File: rtl/rs232tx_fifo.sv
// ---------------------------------------------------------------------------
// rs232tx_fifo
//   Transmit-side byte FIFO in front of the rs232tx serializer. Bytes written
//   by the bus are queued and handed to the serializer one at a time over its
//   d/we/busy handshake. Reports fill level, full/empty and a sticky
//   overflow flag.
//
//   Parameters
//     DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 bytes (1..8)
//
//   Ports
//     clock        system clock, all state on posedge
//     reset_n      asynchronous active-low reset
//     bus          rs232tx_fifo_if.slave (write side, status, serializer side)
//
//   Drain FSM: IDLE pops a byte into tx_d and raises tx_we, ISSUE drops tx_we,
//   HOLD waits one cycle so the serializer's busy (which rises one cycle
//   after the load) is valid before IDLE looks at it again.
// ---------------------------------------------------------------------------
module rs232tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  rs232tx_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [7:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2:0]    level;
  logic                   overflow;
  logic                   tx_we;
  logic [7:0]             tx_d;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   drop;
  logic                   pop;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

  // flush swallows any concurrent write, so it neither pushes nor sets overflow.
  assign push = bus.wr_en & ~full & ~bus.flush;
  assign drop = bus.wr_en &  full & ~bus.flush;

  // -------------------------------------------------------------------------
  // Drain FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: every clocked state update uses <= so all registers see the
      // pre-edge values of each other, exactly like the flops they become.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        // flush has priority: no byte is issued on the flush edge.
        if (!empty && !bus.tx_busy && !bus.flush) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pointers, level, overflow and serializer outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      tx_we    <= 1'b0;
      tx_d     <= 8'h00;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end

      // Set wins over clear when a drop and clr_ovf coincide.
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow <= 1'b0;
      end

      // tx_we is high only in ISSUE, so it can never be high two cycles running.
      tx_we <= pop;
      if (pop) tx_d <= mem[rd_ptr];
    end
  end

  // NOTE: the storage array is deliberately not reset; the level counter
  // alone decides which entries are valid, and leaving the RAM out of the
  // reset net lets it map onto plain memory.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.overflow = overflow;
  assign bus.tx_we    = tx_we;
  assign bus.tx_d     = tx_d;

endmodule

// File: tb/tb_rs232tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_rs232tx_fifo
//   Directed self-checking bench for rs232tx_fifo (DEPTH_LOG2 = 4).
//   Inputs are driven right after a falling edge and outputs are checked on
//   the following falling edge. A small serializer model supplies tx_busy
//   when use_model is set; otherwise tx_busy is forced from the stimulus.
// ---------------------------------------------------------------------------
module tb_rs232tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int BUSY_CYC   = 40;   // serializer busy time: 10 bits x period 4

  logic clock;
  logic reset_n;

  rs232tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  rs232tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- serializer busy model ----------------
  logic use_model  = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   model_cnt  = 0;

  assign bus.tx_busy = use_model ? model_busy : force_busy;

  // Latches on the edge that ends the tx_we cycle; busy visible one cycle later.
  always @(posedge clock) begin
    if (bus.tx_we) begin
      model_busy <= 1'b1;
      model_cnt  <= BUSY_CYC;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_busy <= 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] rx_q[$];
  logic       prev_we   = 1'b0;
  logic       mon_chk   = 1'b0;
  int         busy_viol = 0;
  int         adj_viol  = 0;

  always @(negedge clock) begin
    prev_we <= bus.tx_we;
    if (bus.tx_we) begin
      rx_q.push_back(bus.tx_d);
      if (prev_we)                 adj_viol  <= adj_viol + 1;
      if (mon_chk && bus.tx_busy)  busy_viol <= busy_viol + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
    bus.clr_ovf = 1'b0;
    reset_n     = 1'b0;

    // 1 Reset state
    repeat (3) @(negedge clock);
    check("rst_empty",    {31'd0, bus.empty},    32'd1);
    check("rst_full",     {31'd0, bus.full},     32'd0);
    check("rst_level",    {27'd0, bus.level},    32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_tx_we",    {31'd0, bus.tx_we},    32'd0);
    check("rst_tx_d",     {24'd0, bus.tx_d},     32'h00);
    reset_n = 1'b1;
    @(negedge clock);

    // 2 Single byte latency
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    @(negedge clock);
    bus.wr_en = 1'b0;
    check("single_we_c1",    {31'd0, bus.tx_we}, 32'd0);
    check("single_level_c1", {27'd0, bus.level}, 32'd1);
    @(negedge clock);
    check("single_we_c2",    {31'd0, bus.tx_we}, 32'd1);
    check("single_d_c2",     {24'd0, bus.tx_d},  32'hA5);
    check("single_level_c2", {27'd0, bus.level}, 32'd0);
    check("single_empty_c2", {31'd0, bus.empty}, 32'd1);
    @(negedge clock);
    check("single_we_c3",    {31'd0, bus.tx_we}, 32'd0);
    repeat (3) @(negedge clock);

    // 3 Burst against the serializer model
    base      = rx_q.size();
    use_model = 1'b1;
    mon_chk   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
    wait_rx(base + 5, 400);
    check("burst_count", rx_q.size() - base, 32'd5);
    for (int i = 0; i < 5 && base + i < rx_q.size(); i++)
      check($sformatf("burst_byte%0d", i), {24'd0, rx_q[base+i]}, 32'(i + 1));
    for (int i = 0; i < 60 && model_busy; i++) @(negedge clock);
    mon_chk = 1'b0;
    check("burst_busy_viol", busy_viol, 32'd0);
    check("burst_empty",     {31'd0, bus.empty}, 32'd1);

    // 4 Fill, overflow, clear, drain with pointer wrap
    use_model  = 1'b0;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
      @(negedge clock);
    end
    check("fill_full",     {31'd0, bus.full},     32'd1);
    check("fill_level",    {27'd0, bus.level},    32'd16);
    check("fill_ovf_pre",  {31'd0, bus.overflow}, 32'd0);
    bus.wr_data = 8'hEE;
    @(negedge clock);
    bus.wr_en = 1'b0;
    check("fill_ovf",      {31'd0, bus.overflow}, 32'd1);
    check("fill_level17",  {27'd0, bus.level},    32'd16);
    bus.clr_ovf = 1'b1;
    @(negedge clock);
    bus.clr_ovf = 1'b0;
    check("fill_clr_ovf",  {31'd0, bus.overflow}, 32'd0);
    base      = rx_q.size();
    use_model = 1'b1;
    wait_rx(base + 16, 1200);
    check("drain_count", rx_q.size() - base, 32'd16);
    for (int i = 0; i < 16 && base + i < rx_q.size(); i++)
      check($sformatf("drain_byte%0d", i), {24'd0, rx_q[base+i]}, 32'(8'h10 + i));
    for (int i = 0; i < 60 && model_busy; i++) @(negedge clock);
    check("drain_empty", {31'd0, bus.empty}, 32'd1);

    // 5 Simultaneous push and pop
    use_model  = 1'b0;
    force_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h50 + i);
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
    @(negedge clock);
    check("sim_level15", {27'd0, bus.level}, 32'd15);
    force_busy = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h5F;
    @(negedge clock);
    force_busy = 1'b1;
    check("sim_pp_level", {27'd0, bus.level}, 32'd15);
    check("sim_pp_we",    {31'd0, bus.tx_we}, 32'd1);
    check("sim_pp_d",     {24'd0, bus.tx_d},  32'h50);
    bus.wr_data = 8'h70;
    @(negedge clock);
    bus.wr_en = 1'b0;
    check("sim_full",      {31'd0, bus.full},  32'd1);
    check("sim_level16",   {27'd0, bus.level}, 32'd16);
    @(negedge clock);
    force_busy = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h71;
    @(negedge clock);
    force_busy = 1'b1;
    bus.wr_en = 1'b0;
    check("simfull_level", {27'd0, bus.level},    32'd15);
    check("simfull_ovf",   {31'd0, bus.overflow}, 32'd1);
    check("simfull_we",    {31'd0, bus.tx_we},    32'd1);
    check("simfull_d",     {24'd0, bus.tx_d},     32'h51);
    bus.clr_ovf = 1'b1;
    @(negedge clock);
    bus.clr_ovf = 1'b0;
    bus.flush   = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("sim_flush_level", {27'd0, bus.level},    32'd0);
    check("sim_flush_ovf",   {31'd0, bus.overflow}, 32'd0);
    repeat (3) @(negedge clock);

    // 6a Flush during HOLD
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
    @(negedge clock);
    check("fl_level6", {27'd0, bus.level}, 32'd6);
    base       = rx_q.size();
    force_busy = 1'b0;
    @(negedge clock);
    force_busy = 1'b1;
    check("fl_issue_we", {31'd0, bus.tx_we}, 32'd1);
    @(negedge clock);
    check("fl_hold_we",  {31'd0, bus.tx_we}, 32'd0);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("fl_level0", {27'd0, bus.level}, 32'd0);
    force_busy = 1'b0;
    repeat (10) @(negedge clock);
    check("fl_count", rx_q.size() - base, 32'd1);
    if (rx_q.size() > base) check("fl_inflight", {24'd0, rx_q[base]}, 32'h60);
    check("fl_empty", {31'd0, bus.empty}, 32'd1);

    // 6b Asynchronous reset mid-transmission (overflow set first)
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h80 + i);
      @(negedge clock);
    end
    bus.wr_en = 1'b0;
    check("rs_pre_ovf", {31'd0, bus.overflow}, 32'd1);
    force_busy = 1'b0;
    @(negedge clock);
    check("rs_pre_we",  {31'd0, bus.tx_we}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_we",    {31'd0, bus.tx_we},    32'd0);
    check("rs_d",     {24'd0, bus.tx_d},     32'h00);
    check("rs_level", {27'd0, bus.level},    32'd0);
    check("rs_empty", {31'd0, bus.empty},    32'd1);
    check("rs_full",  {31'd0, bus.full},     32'd0);
    check("rs_ovf",   {31'd0, bus.overflow}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("rs_post_level", {27'd0, bus.level}, 32'd0);
    check("rs_post_we",    {31'd0, bus.tx_we}, 32'd0);
    check("adjacent_we",   adj_viol,           32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
